pc_sequencer: RTL and testbench

Fetch-stage program-counter sequencer for the pipelined MIPS core. It owns the PC register and applies the 2-bit next-PC select produced by the decode-stage branch decision logic: sequential, branch taken, jump, or jump-register. Redirects that arrive while fetch is frozen by instruction-memory back-pressure are buffered and applied on release. It sits between the D-stage branch comparator/select logic and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register applying the D-stage next-PC select, buffering redirects under stall.
// Optional feature: define PC_ALIGN_CHECK_EN to reject misaligned targets and pulse addr_err.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_F,
    output logic [31:0] pc_plus4_F,
    output logic        redirect_pend,
    output logic        addr_err
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pend_target_r;
    logic        redirect_pend_r;
    logic        addr_err_r;

    logic        redirect_s;
    logic        accept_s;
    logic        misaligned_s;
    logic [31:0] sel_target_s;
    logic [31:0] target_s;

    assign redirect_s = (pcsrc != 2'b00);

    // Pick the target addressed by the next-PC select
    always_comb begin
        sel_target_s = 32'h0000_0000;
        case (pcsrc)
            2'b01:   sel_target_s = br_target;
            2'b10:   sel_target_s = j_target;
            2'b11:   sel_target_s = reg_target;
            default: sel_target_s = 32'h0000_0000;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    // A misaligned target turns the cycle into a plain sequential/hold cycle
    always_comb begin
        target_s     = sel_target_s;
        misaligned_s = 1'b0;
        accept_s     = 1'b0;
        if (redirect_s && (sel_target_s[1:0] != 2'b00)) begin
            misaligned_s = 1'b1;
            accept_s     = 1'b0;
        end else begin
            misaligned_s = 1'b0;
            accept_s     = redirect_s;
        end
    end
`else
    // Without the check, word alignment is enforced by clearing the low bits
    always_comb begin
        target_s     = sel_target_s & 32'hFFFF_FFFC;
        misaligned_s = 1'b0;
        accept_s     = redirect_s;
    end
`endif

    // PC / pending-redirect state machine; a live redirect always beats the buffered one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_RUN;
            pc_r            <= RESET_PC;
            pend_target_r   <= 32'h0000_0000;
            redirect_pend_r <= 1'b0;
            addr_err_r      <= 1'b0;
        end else begin
            addr_err_r <= misaligned_s;
            case (state_r)
                ST_RUN: begin
                    if (!fetch_stall) begin
                        pc_r <= accept_s ? target_s : (pc_r + 32'd4);
                    end else if (accept_s) begin
                        pend_target_r   <= target_s;
                        redirect_pend_r <= 1'b1;
                        state_r         <= ST_PEND;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PEND: begin
                    if (fetch_stall) begin
                        if (accept_s) begin
                            pend_target_r <= target_s;
                        end else begin
                            pend_target_r <= pend_target_r;
                        end
                    end else begin
                        pc_r            <= accept_s ? target_s : pend_target_r;
                        pend_target_r   <= 32'h0000_0000;
                        redirect_pend_r <= 1'b0;
                        state_r         <= ST_RUN;
                    end
                end
                default: begin
                    state_r         <= ST_RUN;
                    redirect_pend_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc_F          = pc_r;
    assign pc_plus4_F    = pc_r + 32'd4;
    assign redirect_pend = redirect_pend_r;
    assign addr_err      = addr_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run against a behavioural model.
// Build with PC_ALIGN_CHECK_EN defined to exercise the alignment-check variant.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        fetch_stall;
    logic [1:0]  pcsrc;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] reg_target;
    logic [31:0] pc_F;
    logic [31:0] pc_plus4_F;
    logic        redirect_pend;
    logic        addr_err;

    int n_checks = 0;
    int n_fails  = 0;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_stall   (fetch_stall),
        .pcsrc         (pcsrc),
        .br_target     (br_target),
        .j_target      (j_target),
        .reg_target    (reg_target),
        .pc_F          (pc_F),
        .pc_plus4_F    (pc_plus4_F),
        .redirect_pend (redirect_pend),
        .addr_err      (addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic stall, input logic [1:0] sel,
                         input logic [31:0] br, input logic [31:0] jt, input logic [31:0] rt);
        fetch_stall = stall;
        pcsrc       = sel;
        br_target   = br;
        j_target    = jt;
        reg_target  = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        repeat (2) tick();
        n_checks++;
        if (pc_F !== RST_PC) begin n_fails++; $display("FAIL reset_pc: got %h want %h", pc_F, RST_PC); end
        n_checks++;
        if (pc_plus4_F !== 32'h0000_3004) begin n_fails++; $display("FAIL reset_plus4: got %h want %h", pc_plus4_F, 32'h0000_3004); end
        n_checks++;
        if (redirect_pend !== 1'b0) begin n_fails++; $display("FAIL reset_pend: got %b want 0", redirect_pend); end
        n_checks++;
        if (addr_err !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %b want 0", addr_err); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = RST_PC + 32'(4 * i);
            n_checks++;
            if (pc_F !== exp_pc || pc_plus4_F !== exp_pc + 32'd4) begin
                n_fails++;
                $display("FAIL seq_%0d: pc %h/%h want %h/%h", i, pc_F, pc_plus4_F, exp_pc, exp_pc + 32'd4);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'b10, 32'h0, 32'h0000_3200, 32'h0);
        tick();
        n_checks++;
        if (redirect_pend !== 1'b1) begin n_fails++; $display("FAIL pre_reset_pend: got %b want 1", redirect_pend); end
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (pc_F !== RST_PC || redirect_pend !== 1'b0) begin
            n_fails++;
            $display("FAIL async_reset: pc %h pend %b want %h pend 0", pc_F, redirect_pend, RST_PC);
        end
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== 32'h0000_3004) begin n_fails++; $display("FAIL post_reset_run: got %h want %h", pc_F, 32'h0000_3004); end
    endtask

    task automatic test_redirects();
        logic [1:0]  sel [3];
        logic [31:0] tgt [3];
        sel = '{2'b01, 2'b10, 2'b11};
        tgt = '{32'h0000_3100, 32'h0000_3400, 32'h0000_3800};
        repeat (3) tick();
        n_checks++;
        if (pc_F !== 32'h0000_3010) begin n_fails++; $display("FAIL reach_3010: got %h want %h", pc_F, 32'h0000_3010); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, sel[i], tgt[0], tgt[1], tgt[2]);
            tick();
            n_checks++;
            if (pc_F !== tgt[i]) begin n_fails++; $display("FAIL redirect_%0d: got %h want %h", i, pc_F, tgt[i]); end
        end
    endtask

    task automatic test_stall_pending();
        drive(1'b1, 2'b10, 32'h0, 32'h0000_3200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
            n_checks++;
            if (pc_F !== 32'h0000_3800 || redirect_pend !== 1'b1) begin
                n_fails++;
                $display("FAIL stall_hold_%0d: pc %h pend %b want 00003800 pend 1", i, pc_F, redirect_pend);
            end
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== 32'h0000_3200 || redirect_pend !== 1'b0) begin
            n_fails++;
            $display("FAIL stall_release: pc %h pend %b want 00003200 pend 0", pc_F, redirect_pend);
        end
    endtask

    task automatic test_newest_wins();
        drive(1'b1, 2'b10, 32'h0, 32'h0000_3300, 32'h0);
        tick();
        drive(1'b1, 2'b11, 32'h0, 32'h0, 32'h0000_3600);
        tick();
        n_checks++;
        if (pc_F !== 32'h0000_3200 || redirect_pend !== 1'b1) begin
            n_fails++;
            $display("FAIL newest_hold: pc %h pend %b want 00003200 pend 1", pc_F, redirect_pend);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== 32'h0000_3600) begin n_fails++; $display("FAIL newest_release: got %h want %h", pc_F, 32'h0000_3600); end
    endtask

    task automatic test_release_redirect();
        drive(1'b1, 2'b10, 32'h0, 32'h0000_3200, 32'h0);
        tick();
        drive(1'b0, 2'b01, 32'h0000_3A00, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== 32'h0000_3A00 || redirect_pend !== 1'b0) begin
            n_fails++;
            $display("FAIL release_redirect: pc %h pend %b want 00003a00 pend 0", pc_F, redirect_pend);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== 32'h0000_3A04) begin n_fails++; $display("FAIL after_release: got %h want %h", pc_F, 32'h0000_3A04); end
    endtask

    task automatic test_misaligned();
        logic [31:0] exp_pc1;
        logic [31:0] exp_pc2;
        logic        exp_err;
`ifdef PC_ALIGN_CHECK_EN
        exp_pc1 = 32'h0000_3A08;
        exp_pc2 = 32'h0000_3A0C;
        exp_err = 1'b1;
`else
        exp_pc1 = 32'h0000_3100;
        exp_pc2 = 32'h0000_3104;
        exp_err = 1'b0;
`endif
        drive(1'b0, 2'b01, 32'h0000_3102, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== exp_pc1 || addr_err !== exp_err) begin
            n_fails++;
            $display("FAIL misaligned: pc %h err %b want %h err %b", pc_F, addr_err, exp_pc1, exp_err);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== exp_pc2 || addr_err !== 1'b0) begin
            n_fails++;
            $display("FAIL misaligned_next: pc %h err %b want %h err 0", pc_F, addr_err, exp_pc2);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== 32'hFFFF_FFFC || pc_plus4_F !== 32'h0000_0000) begin
            n_fails++;
            $display("FAIL wrap_top: pc %h plus4 %h want fffffffc 00000000", pc_F, pc_plus4_F);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (pc_F !== 32'h0000_0000 || pc_plus4_F !== 32'h0000_0004) begin
            n_fails++;
            $display("FAIL wrap: pc %h plus4 %h want 00000000 00000004", pc_F, pc_plus4_F);
        end
    endtask

    // Random traffic against a model holding the PC and an optional buffered target
    task automatic test_random();
        logic [31:0] m_pc;
        logic [31:0] m_pend_t;
        bit          m_pend_v;
        bit          m_err;
        logic [31:0] t [3];
        logic [31:0] tgt;
        bit          redir;
        bit          stall;
        logic [1:0]  sel;

        @(posedge clk);
        #2 reset = 1'b1;
        #4 reset = 1'b0;
        m_pc     = RST_PC;
        m_pend_t = 32'h0;
        m_pend_v = 1'b0;
        m_err    = 1'b0;

        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                t[k] = $urandom;
                if ($urandom_range(0, 3) != 0) t[k][1:0] = 2'b00;
            end
            stall = ($urandom_range(0, 9) < 4);
            sel   = 2'($urandom_range(0, 3));
            drive(stall, sel, t[0], t[1], t[2]);

            redir = (sel != 2'b00);
            tgt   = redir ? t[sel - 2'd1] : 32'h0;
            m_err = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (redir && tgt[1:0] != 2'b00) begin
                redir = 1'b0;
                m_err = 1'b1;
            end
`else
            tgt = {tgt[31:2], 2'b00};
`endif
            if (!stall) begin
                if (redir)         m_pc = tgt;
                else if (m_pend_v) m_pc = m_pend_t;
                else               m_pc = m_pc + 32'd4;
                m_pend_v = 1'b0;
            end else if (redir) begin
                m_pend_v = 1'b1;
                m_pend_t = tgt;
            end

            tick();
            n_checks++;
            if (pc_F !== m_pc || pc_plus4_F !== m_pc + 32'd4 ||
                redirect_pend !== m_pend_v || addr_err !== m_err) begin
                n_fails++;
                $display("FAIL random_%0d: pc %h plus4 %h pend %b err %b want pc %h plus4 %h pend %b err %b",
                         n, pc_F, pc_plus4_F, redirect_pend, addr_err, m_pc, m_pc + 32'd4, m_pend_v, m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_sequential();
        test_async_reset();
        test_redirects();
        test_stall_pending();
        test_newest_wins();
        test_release_redirect();
        test_misaligned();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
